// File: rtl/stn_fb_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : stn_fb_writer_if
// Description : STN panel capture bus, framebuffer write port and geometry
//               debug signals of the framebuffer writer.
// Revision    : 1.0 - initial release
// ============================================================================
interface stn_fb_writer_if #(
    parameter int ADDR_W = 17
) ();
    logic              stn_frame;
    logic              stn_line;
    logic              stn_shift;
    logic [3:0]        stn_data;
    logic              fb_wr_en;
    logic [ADDR_W-1:0] fb_wr_addr;
    logic [3:0]        fb_wr_data;
    logic              overflow;
    logic              dbg_line;
    logic              dbg_frame;
    logic [3:0]        dbg_pixelbus;
    logic [9:0]        dbg_frame_width;
    logic [8:0]        dbg_frame_height;
    logic [9:0]        dbg_frame_x;
    logic [8:0]        dbg_frame_y;

    // The writer: consumes the panel bus, drives the framebuffer and debug taps.
    modport master (
        input  stn_frame, stn_line, stn_shift, stn_data,
        output fb_wr_en, fb_wr_addr, fb_wr_data, overflow,
        output dbg_line, dbg_frame, dbg_pixelbus, dbg_frame_width,
        output dbg_frame_height, dbg_frame_x, dbg_frame_y
    );

    modport slave (
        output stn_frame, stn_line, stn_shift, stn_data,
        input  fb_wr_en, fb_wr_addr, fb_wr_data, overflow,
        input  dbg_line, dbg_frame, dbg_pixelbus, dbg_frame_width,
        input  dbg_frame_height, dbg_frame_x, dbg_frame_y
    );
endinterface
`default_nettype wire

// File: rtl/stn_fb_writer.sv
`default_nettype none
// ============================================================================
// Module      : stn_fb_writer
// Description : Samples the asynchronous STN panel bus, packs shifted nibbles
//               into framebuffer writes and measures the panel geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module stn_fb_writer #(
    parameter int MAX_WIDTH  = 640,
    parameter int MAX_HEIGHT = 480,
    parameter int ADDR_W     = 17
) (
    input  wire logic         clk,
    input  wire logic         rst,
    stn_fb_writer_if.master   bus
);
    localparam logic [8:0]        c_XWORDS    = 9'(MAX_WIDTH / 4);
    localparam logic [9:0]        c_HEIGHT    = 10'(MAX_HEIGHT);
    localparam logic [ADDR_W-1:0] c_LINE_STEP = ADDR_W'(MAX_WIDTH / 4);

    localparam logic [0:0] S_WAIT_FRAME = 1'b0;
    localparam logic [0:0] S_CAPTURE    = 1'b1;

    // Panel bit positions inside the synchronizer vector.
    localparam int c_B_FRAME = 6;
    localparam int c_B_LINE  = 5;
    localparam int c_B_SHIFT = 4;

    logic [6:0]        r_sync1;
    logic [6:0]        r_sync2;
    logic              r_line3;
    logic              r_shift3;
    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic [7:0]        r_xword;
    logic [8:0]        r_y;
    logic [ADDR_W-1:0] r_line_base;
    logic              r_fb_wr_en;
    logic [ADDR_W-1:0] r_fb_wr_addr;
    logic [3:0]        r_fb_wr_data;
    logic              r_overflow;
    logic [3:0]        r_pixelbus;
    logic [9:0]        r_frame_width;
    logic [8:0]        r_frame_height;

    logic [6:0]        w_panel;
    logic              w_shift_ev;
    logic              w_line_ev;
    logic              w_frame_ev;
    logic [3:0]        w_nibble;
    logic              w_do_shift;
    logic              w_do_line;
    logic              w_do_frame;
    logic              w_start;
    logic              w_in_range;
    logic [7:0]        w_xword_inc;
    logic [7:0]        w_xword_seen;
    logic [8:0]        w_y_inc;

    assign w_panel    = {bus.stn_frame, bus.stn_line, bus.stn_shift, bus.stn_data};
    assign w_shift_ev = r_shift3 & ~r_sync2[c_B_SHIFT];
    assign w_line_ev  = ~r_line3 & r_sync2[c_B_LINE];
    assign w_frame_ev = w_line_ev & r_sync2[c_B_FRAME];
    // Stage 2 data is time-aligned with the stage 2 shift level that shows the edge.
    assign w_nibble   = r_sync2[3:0];

    assign w_in_range   = ({1'b0, r_xword} < c_XWORDS) && ({1'b0, r_y} < c_HEIGHT);
    assign w_xword_inc  = (r_xword == 8'hFF) ? r_xword : r_xword + 8'd1;
    // A shift coinciding with a line event is counted before the width is taken.
    assign w_xword_seen = w_do_shift ? w_xword_inc : r_xword;
    assign w_y_inc      = (r_y == 9'h1FF) ? r_y : r_y + 9'd1;

    always_comb begin
        w_state_next = r_state;
        w_do_shift   = 1'b0;
        w_do_line    = 1'b0;
        w_do_frame   = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            S_WAIT_FRAME: begin
                if (w_frame_ev) begin
                    w_state_next = S_CAPTURE;
                    w_start      = 1'b1;
                end
            end
            S_CAPTURE: begin
                w_do_shift = w_shift_ev;
                w_do_line  = w_line_ev;
                w_do_frame = w_frame_ev;
            end
            default: w_state_next = S_WAIT_FRAME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_WAIT_FRAME;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1        <= '0;
            r_sync2        <= '0;
            r_line3        <= 1'b0;
            r_shift3       <= 1'b0;
            r_xword        <= '0;
            r_y            <= '0;
            r_line_base    <= '0;
            r_fb_wr_en     <= 1'b0;
            r_fb_wr_addr   <= '0;
            r_fb_wr_data   <= '0;
            r_overflow     <= 1'b0;
            r_pixelbus     <= '0;
            r_frame_width  <= '0;
            r_frame_height <= '0;
        end else begin
            r_sync1    <= w_panel;
            r_sync2    <= r_sync1;
            r_line3    <= r_sync2[c_B_LINE];
            r_shift3   <= r_sync2[c_B_SHIFT];
            r_fb_wr_en <= 1'b0;

            if (w_do_shift) begin
                r_pixelbus <= w_nibble;
                if (w_in_range) begin
                    r_fb_wr_en   <= 1'b1;
                    r_fb_wr_addr <= r_line_base + ADDR_W'(r_xword);
                    r_fb_wr_data <= w_nibble;
                end else begin
                    r_overflow <= 1'b1;
                end
                r_xword <= w_xword_inc;
            end

            // Line handling overrides the x advance of a coincident shift.
            if (w_do_line) begin
                if (w_xword_seen != 8'd0) begin
                    // 4*255 = 1020 never reaches the 1023 ceiling.
                    r_frame_width <= {w_xword_seen, 2'b00};
                end
                r_xword <= '0;
                if (w_do_frame) begin
                    r_frame_height <= w_y_inc;
                    r_y            <= '0;
                    r_line_base    <= '0;
                end else begin
                    r_y <= w_y_inc;
                    if ({1'b0, r_y} < c_HEIGHT) begin
                        r_line_base <= r_line_base + c_LINE_STEP;
                    end
                end
            end

            if (w_start) begin
                r_xword     <= '0;
                r_y         <= '0;
                r_line_base <= '0;
            end
        end
    end

    assign bus.fb_wr_en         = r_fb_wr_en;
    assign bus.fb_wr_addr       = r_fb_wr_addr;
    assign bus.fb_wr_data       = r_fb_wr_data;
    assign bus.overflow         = r_overflow;
    assign bus.dbg_line         = r_sync2[c_B_LINE];
    assign bus.dbg_frame        = r_sync2[c_B_FRAME];
    assign bus.dbg_pixelbus     = r_pixelbus;
    assign bus.dbg_frame_width  = r_frame_width;
    assign bus.dbg_frame_height = r_frame_height;
    assign bus.dbg_frame_x      = {r_xword, 2'b00};
    assign bus.dbg_frame_y      = r_y;
endmodule
`default_nettype wire

// File: tb/tb_stn_fb_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stn_fb_writer
// Description : Scoreboard bench for stn_fb_writer (reduced frame height).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stn_fb_writer;
    localparam int MW = 640;
    localparam int MH = 32;
    localparam int XW = MW / 4;
    localparam int AW = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stn_fb_writer_if #(.ADDR_W(AW)) bus ();

    stn_fb_writer #(
        .MAX_WIDTH (MW),
        .MAX_HEIGHT(MH),
        .ADDR_W    (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int checks = 0;
    int errors = 0;

    logic [AW+3:0] exp_q[$];
    logic [AW-1:0] last_addr = '0;
    logic          prev_en = 1'b0;

    // Reference model state
    bit mcap;
    bit movf;
    int mx, my, mw, mh;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mcap = 0; movf = 0; mx = 0; my = 0; mw = 0; mh = 0;
    endtask

    task automatic model_shift(input logic [3:0] d);
        if (mcap) begin
            if (mx < XW && my < MH) exp_q.push_back({AW'(my * XW + mx), d});
            else movf = 1;
            if (mx < 255) mx++;
        end
    endtask

    task automatic model_line(input bit f);
        if (!mcap) begin
            if (f) begin mcap = 1; mx = 0; my = 0; end
        end else begin
            if (mx != 0) mw = (4 * mx > 1023) ? 1023 : 4 * mx;
            if (f) begin
                mh = (my + 1 > 511) ? 511 : my + 1;
                mx = 0; my = 0;
            end else begin
                mx = 0;
                if (my < 511) my++;
            end
        end
    endtask

    task automatic shift_nib(input logic [3:0] d);
        @(negedge clk); bus.stn_data = d; bus.stn_shift = 1'b1;
        @(negedge clk);
        @(negedge clk); bus.stn_shift = 1'b0;
        model_shift(d);
    endtask

    task automatic line_pulse(input bit f);
        @(negedge clk); bus.stn_line = 1'b1; bus.stn_frame = f;
        @(negedge clk);
        @(negedge clk); bus.stn_line = 1'b0; bus.stn_frame = 1'b0;
        model_line(f);
    endtask

    // Shift falling edge and line rising edge land in the same sample.
    task automatic shift_with_line(input logic [3:0] d);
        @(negedge clk); bus.stn_data = d; bus.stn_shift = 1'b1;
        @(negedge clk);
        @(negedge clk); bus.stn_shift = 1'b0; bus.stn_line = 1'b1;
        model_shift(d);
        @(negedge clk);
        @(negedge clk); bus.stn_line = 1'b0;
        model_line(1'b0);
    endtask

    task automatic settle();
        repeat (5) @(negedge clk);
    endtask

    task automatic chk_geom(input string tag);
        chk({tag, "_width"},  32'(bus.dbg_frame_width),  32'(mw));
        chk({tag, "_height"}, 32'(bus.dbg_frame_height), 32'(mh));
        chk({tag, "_x"},      32'(bus.dbg_frame_x),      32'(4 * mx));
        chk({tag, "_y"},      32'(bus.dbg_frame_y),      32'(my));
        chk({tag, "_ovf"},    32'(bus.overflow),         32'(movf));
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every write strobe is matched against the scoreboard.
    always @(negedge clk) begin
        if (bus.fb_wr_en === 1'b1) begin
            logic [AW+3:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual addr=%0d data=%h required no write",
                         bus.fb_wr_addr, bus.fb_wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({bus.fb_wr_addr, bus.fb_wr_data} !== e) begin
                    errors++;
                    $display("FAIL write actual addr=%0d data=%h required addr=%0d data=%h",
                             bus.fb_wr_addr, bus.fb_wr_data, e[AW+3:4], e[3:0]);
                end
            end
            checks++;
            if (prev_en) begin
                errors++;
                $display("FAIL back_to_back actual=1 required=0");
            end
            last_addr = bus.fb_wr_addr;
        end
        prev_en = (bus.fb_wr_en === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.stn_frame = 0; bus.stn_line = 0; bus.stn_shift = 0; bus.stn_data = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_wr_en",  32'(bus.fb_wr_en), 0);
        chk("rst_addr",   32'(bus.fb_wr_addr), 0);
        chk("rst_ovf",    32'(bus.overflow), 0);
        chk("rst_dbg",    32'({bus.dbg_line, bus.dbg_frame, bus.dbg_pixelbus,
                               bus.dbg_frame_width, bus.dbg_frame_height}), 0);
        chk("rst_xy",     32'({bus.dbg_frame_x, bus.dbg_frame_y}), 0);
        rst = 1'b0;

        // 1: frame, four nibbles, write exactly 3 clk after the raw falling edge
        line_pulse(1'b1);
        begin
            logic [15:0] nibs;
            nibs = 16'hA5F0;
            for (int i = 0; i < 4; i++) begin
                shift_nib(nibs[15 - 4 * i -: 4]);
                @(negedge clk);
                @(negedge clk); chk("t1_not_early", 32'(bus.fb_wr_en), 0);
                @(negedge clk); chk("t1_latency",   32'(bus.fb_wr_en), 1);
            end
        end
        settle();
        chk("t1_last_addr", 32'(last_addr), 3);
        chk("t1_pixelbus",  32'(bus.dbg_pixelbus), 0);
        chk_geom("t1");

        // 2: frame, 2 shifts, line, 1 shift -> addr 160
        line_pulse(1'b1);
        shift_nib(4'h9);
        shift_nib(4'h6);
        line_pulse(1'b0);
        shift_nib(4'h3);
        settle();
        chk("t2_last_addr", 32'(last_addr), 160);
        chk("t2_width",     32'(bus.dbg_frame_width), 8);
        chk("t2_y",         32'(bus.dbg_frame_y), 1);
        chk("t2_pixelbus",  32'(bus.dbg_pixelbus), 3);
        chk_geom("t2");

        // 3: activity before any frame event is ignored
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();
        shift_nib(4'h7);
        line_pulse(1'b0);
        shift_nib(4'h8);
        line_pulse(1'b0);
        settle();
        chk("t3_idle_dbg", 32'({bus.dbg_pixelbus, bus.dbg_frame_width, bus.dbg_frame_height}), 0);
        chk("t3_idle_xy",  32'({bus.dbg_frame_x, bus.dbg_frame_y}), 0);
        line_pulse(1'b1);
        shift_nib(4'hC);
        settle();
        chk("t3_first_addr", 32'(last_addr), 0);
        chk_geom("t3");

        // 4: full reduced-height frame ending in a frame event
        line_pulse(1'b1);
        for (int l = 0; l < MH; l++) begin
            for (int i = 0; i < XW; i++) shift_nib(4'((l + i) & 15));
            line_pulse(l == MH - 1);
        end
        settle();
        chk("t4_last_addr", 32'(last_addr), XW * MH - 1);
        chk("t4_width",     32'(bus.dbg_frame_width), 640);
        chk("t4_height",    32'(bus.dbg_frame_height), MH);
        chk("t4_ovf",       32'(bus.overflow), 0);
        chk_geom("t4");

        // 5: 164 shifts on a line -> 4 dropped, sticky overflow
        for (int i = 0; i < 164; i++) shift_nib(4'(i & 15));
        line_pulse(1'b0);
        settle();
        chk("t5_width", 32'(bus.dbg_frame_width), 656);
        chk("t5_ovf",   32'(bus.overflow), 1);
        line_pulse(1'b1);
        shift_nib(4'h1);
        line_pulse(1'b1);
        settle();
        chk("t5_ovf_sticky", 32'(bus.overflow), 1);
        chk_geom("t5");

        // 6: coincident shift/line, then reset mid-line
        shift_nib(4'hE);
        shift_with_line(4'h5);
        settle();
        chk("t6_coinc_addr", 32'(last_addr), 1);
        chk("t6_coinc_y",    32'(bus.dbg_frame_y), 1);
        chk("t6_coinc_x",    32'(bus.dbg_frame_x), 0);
        shift_nib(4'h2);
        shift_nib(4'h4);
        settle();
        chk("t6_mid_addr", 32'(last_addr), 161);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_wr_en", 32'(bus.fb_wr_en), 0);
        chk("t6_rst_dbg",   32'({bus.dbg_line, bus.dbg_frame, bus.dbg_pixelbus,
                                 bus.dbg_frame_width, bus.dbg_frame_height}), 0);
        chk("t6_rst_xy",    32'({bus.dbg_frame_x, bus.dbg_frame_y}), 0);
        chk("t6_rst_ovf",   32'(bus.overflow), 0);
        rst = 1'b0;
        model_reset();
        shift_nib(4'hB);
        settle();
        chk("t6_wait_x", 32'(bus.dbg_frame_x), 0);
        line_pulse(1'b1);
        shift_nib(4'hD);
        settle();
        chk("t6_restart_addr", 32'(last_addr), 0);
        chk_geom("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/stn_fb_writer.md
Name: stn_fb_writer

Overview:
Capture side of the STN-to-HDMI bridge: samples the STN panel bus (frame marker, line pulse, shift clock, 4-bit data) in the system clock domain. Packs each shifted nibble into a framebuffer write, advancing x/y from the panel's own timing. Measures the panel frame geometry and drives the dbg_* signals consumed by the pixel generator. The pixel generator is the framebuffer reader; this block is the framebuffer writer.

Parameters:
MAX_WIDTH, 640, max captured pixels per line; multiple of 4.
MAX_HEIGHT, 480, max captured lines per frame.
ADDR_W, 17, framebuffer word-address width; must hold MAX_WIDTH/4*MAX_HEIGHT.

Ports:
clk  in  1  system clock; only clock.
rst  in  1  synchronous, active-high reset.
stn_frame  in  1  panel FLM, async to clk.
stn_line  in  1  panel LP/CL1, async.
stn_shift  in  1  panel CL2 shift clock, async.
stn_data  in  4  panel pixel nibble, async; bit 3 = leftmost pixel.
fb_wr_en  out  1  one-cycle framebuffer write strobe.
fb_wr_addr  out  ADDR_W  word address = y*(MAX_WIDTH/4) + xword.
fb_wr_data  out  4  4 pixels; bit 3 = lowest x.
overflow  out  1  sticky: a write was dropped as out of range.
dbg_line  out  1  synchronized stn_line level.
dbg_frame  out  1  synchronized stn_frame level.
dbg_pixelbus  out  4  last sampled nibble.
dbg_frame_width  out  10  pixels in the last completed line (4*shifts), saturating at 1023.
dbg_frame_height  out  9  lines in the last completed frame, saturating at 511.
dbg_frame_x  out  10  current pixel x (4*xword).
dbg_frame_y  out  9  current line y.

Behaviour:
- Reset: synchronous; all outputs, counters and sync flops 0; state WAIT_FRAME. rst mid-line aborts capture; the next write occurs only after a new frame event.
- Input sync: 2-flop synchronizer on all 7 panel bits, plus a 3rd stage on stn_line and stn_shift for edge detection.
- Events, evaluated on synchronized signals:
  - shift event = falling edge of stn_shift; the nibble is taken from the sync stage aligned with that edge.
  - line event = rising edge of stn_line.
  - frame event = line event with synchronized stn_frame high.
- FSM:
  - WAIT_FRAME: ignore shift and line events; on a frame event -> CAPTURE with x=0, y=0, line_base=0; no geometry latched.
  - CAPTURE, shift event:
    - if xword < MAX_WIDTH/4 and y < MAX_HEIGHT: the next cycle has fb_wr_en=1, fb_wr_addr=line_base+xword, fb_wr_data=nibble. Latency is 1 clk after event detection.
    - otherwise: no write and overflow<=1.
    - xword increments in all cases, saturating at 255. dbg_pixelbus updates.
  - CAPTURE, line event (not frame):
    - if xword != 0, dbg_frame_width <= min(4*xword, 1023).
    - xword<=0; y<=y+1, saturating at 511; line_base <= line_base + MAX_WIDTH/4 only while y < MAX_HEIGHT.
  - CAPTURE, frame event: width update as for a line event; dbg_frame_height <= min(y+1, 511); xword<=0, y<=0, line_base<=0.
- Address arithmetic: line_base is a running accumulator with no multiplier; width ADDR_W. Adds are gated so the accumulator never wraps.
- Simultaneous shift and line event in one clk: the shift is processed first (written at the old x/y), then the line advance applies.
- fb_wr_en is never asserted for two consecutive cycles; the shift period is at least 3 clk and the sync stages guarantee this.
- dbg_frame_x = 4*xword and dbg_frame_y = y, both registered.
- overflow clears only on rst.

Test Plan:
1. Reset, then a frame event and 4 shifts with data 0xA,0x5,0xF,0x0 -> 4 writes at addr 0,1,2,3 with matching data, each 1 clk after its detected edge.
2. Frame event, 2 shifts, line event, 1 shift (0x3) -> third write at addr 160 data 0x3; dbg_frame_width=8; dbg_frame_y=1.
3. Shifts and line events before any frame event -> no fb_wr_en and dbg_* stay 0; after the frame event, capture starts at addr 0.
4. Full 640x480 frame (160 shifts/line, 480 lines) ending with a frame event -> last write at addr 76799; dbg_frame_width=640, dbg_frame_height=480, overflow=0.
5. 164 shifts on one line -> writes for xword 0..159 only; overflow=1 and stays set across frames until rst; dbg_frame_width=656.
6. Shift falling edge and line rising edge in the same clk -> write at the old y, then y advances; assert rst mid-line -> fb_wr_en=0, all dbg_*=0, state WAIT_FRAME.
